// File: rtl/gpio_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_filter_pkg                                                 |
// | Brief    : Shared defaults and width helper for the GPIO input filter.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gpio_filter_pkg;

    localparam int GPIO_FILTER_SYNC_STAGES_DEF = 2;
    localparam int GPIO_FILTER_PRESCALE_DEF    = 1;
    localparam int GPIO_FILTER_STABLE_DEF      = 4;

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = (value > 1) ? $clog2(value) : 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_filter_pin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_filter_pin                                                 |
// | Brief    : One pin: synchroniser chain, debounce counter, filtered level   |
// |            and optional rise/fall pulses (GPIO_INPUT_FILTER_EDGE_EN).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_filter_pin
    import gpio_filter_pkg::*;
#(
    parameter int SYNC_STAGES    = GPIO_FILTER_SYNC_STAGES_DEF,
    parameter int STABLE_SAMPLES = GPIO_FILTER_STABLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_filtered
`ifdef GPIO_INPUT_FILTER_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall
`endif
);

    localparam int                 c_CNT_W   = clog2_min1(STABLE_SAMPLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_filtered;
    logic                   w_sync_out;
    logic                   w_differ;
    logic                   w_at_max;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differ   = (w_sync_out != r_filtered);
    assign w_at_max   = (r_cnt == c_CNT_MAX);
    assign o_filtered = r_filtered;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Any tick where the synchronised level agrees with the output restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_filtered <= 1'b0;
        end else if (i_tick) begin
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_at_max) begin
                r_filtered <= w_sync_out;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef GPIO_INPUT_FILTER_EDGE_EN
    logic w_flip;
    logic r_rise;
    logic r_fall;

    assign w_flip = i_tick & w_differ & w_at_max;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_flip & w_sync_out;
            r_fall <= w_flip & ~w_sync_out;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_input_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_input_filter                                               |
// | Brief    : Per-bank GPIO input conditioning: synchroniser plus debounce,   |
// |            shared prescaler. Macro GPIO_INPUT_FILTER_EDGE_EN adds          |
// |            io_rise/io_fall edge pulses.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_input_filter
    import gpio_filter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int SYNC_STAGES    = GPIO_FILTER_SYNC_STAGES_DEF,
    parameter int PRESCALE       = GPIO_FILTER_PRESCALE_DEF,
    parameter int STABLE_SAMPLES = GPIO_FILTER_STABLE_DEF
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic [WIDTH-1:0] io_pins_raw,
    output logic [WIDTH-1:0] io_pins_filtered,
    output logic             io_tick
`ifdef GPIO_INPUT_FILTER_EDGE_EN
    ,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
`endif
);

    if (WIDTH < 1) begin : g_chk_width
        $error("gpio_input_filter: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("gpio_input_filter: SYNC_STAGES must be >= 2");
    end
    if (PRESCALE < 1) begin : g_chk_prescale
        $error("gpio_input_filter: PRESCALE must be >= 1");
    end
    if (STABLE_SAMPLES < 1) begin : g_chk_stable
        $error("gpio_input_filter: STABLE_SAMPLES must be >= 1");
    end

    localparam int                  c_PCNT_W   = clog2_min1(PRESCALE);
    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(PRESCALE - 1);

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [c_PCNT_W-1:0] w_pcnt_next;
    logic                r_tick;

    assign w_pcnt_next = (r_pcnt == c_PCNT_MAX) ? '0 : r_pcnt + 1'b1;
    assign io_tick     = r_tick;

    // Tick is registered from the next count so it is low during reset even when PRESCALE=1.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_next;
            r_tick <= (w_pcnt_next == c_PCNT_MAX);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_filter_pin #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_pin (
            .clk       (io_clock),
            .rst       (io_reset),
            .i_tick    (r_tick),
            .i_raw     (io_pins_raw[i]),
            .o_filtered(io_pins_filtered[i])
`ifdef GPIO_INPUT_FILTER_EDGE_EN
            ,
            .o_rise    (io_rise[i]),
            .o_fall    (io_fall[i])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gpio_input_filter                                            |
// | Brief    : Self-checking bench for gpio_input_filter (two configurations). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_gpio_input_filter;

    localparam int A_W = 8, A_SY = 2, A_P = 1, A_S = 4;
    localparam int B_W = 4, B_SY = 2, B_P = 5, B_S = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [A_W-1:0] raw_a = '0;
    logic [A_W-1:0] filt_a;
    logic           tick_a;
    logic [B_W-1:0] raw_b = '0;
    logic [B_W-1:0] filt_b;
    logic           tick_b;
`ifdef GPIO_INPUT_FILTER_EDGE_EN
    logic [A_W-1:0] rise_a, fall_a;
    logic [B_W-1:0] rise_b, fall_b;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    gpio_input_filter #(.WIDTH(A_W), .SYNC_STAGES(A_SY), .PRESCALE(A_P), .STABLE_SAMPLES(A_S)) dut_a (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_a), .io_pins_filtered(filt_a), .io_tick(tick_a)
`ifdef GPIO_INPUT_FILTER_EDGE_EN
        , .io_rise(rise_a), .io_fall(fall_a)
`endif
    );

    gpio_input_filter #(.WIDTH(B_W), .SYNC_STAGES(B_SY), .PRESCALE(B_P), .STABLE_SAMPLES(B_S)) dut_b (
        .io_clock(clk), .io_reset(rst), .io_pins_raw(raw_b), .io_pins_filtered(filt_b), .io_tick(tick_b)
`ifdef GPIO_INPUT_FILTER_EDGE_EN
        , .io_rise(rise_b), .io_fall(fall_b)
`endif
    );

    // Model: a pin's output flips once the last STABLE tick samples of the
    // synchronised level all disagree with it.
    int         n_m  [2];
    int         hcnt [2];
    logic [7:0] dl   [2][4];
    logic [7:0] hist [2][8];
    logic [7:0] mf   [2];
    logic [7:0] mr   [2];
    logic [7:0] mfl  [2];

    function automatic logic mtick(input int d, input int p);
        return (p == 1) ? (n_m[d] >= 1) : ((n_m[d] % p) == p - 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            n_m[d] = 0; hcnt[d] = 0; mf[d] = '0; mr[d] = '0; mfl[d] = '0;
            for (int j = 0; j < 4; j++) dl[d][j] = '0;
            for (int j = 0; j < 8; j++) hist[d][j] = '0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] raw, input int p, input int s, input int sy);
        logic       tk;
        logic [7:0] so;
        bit         all_diff;
        tk = mtick(d, p);
        so = dl[d][sy-1];
        mr[d] = '0;
        mfl[d] = '0;
        if (tk) begin
            for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = so;
            if (hcnt[d] < 8) hcnt[d]++;
            for (int i = 0; i < 8; i++) begin
                all_diff = (hcnt[d] >= s);
                for (int j = 0; j < s; j++)
                    if (hist[d][j][i] == mf[d][i]) all_diff = 1'b0;
                if (all_diff) begin
                    mf[d][i] = ~mf[d][i];
                    if (mf[d][i]) mr[d][i] = 1'b1;
                    else          mfl[d][i] = 1'b1;
                end
            end
        end
        for (int j = 3; j > 0; j--) dl[d][j] = dl[d][j-1];
        dl[d][0] = raw;
        n_m[d]++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_step(0, raw_a, A_P, A_S, A_SY);
                model_step(1, {4'b0, raw_b}, B_P, B_S, B_SY);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("cmp_filt_a", 32'(filt_a), 32'(mf[0]));
                check("cmp_tick_a", 32'(tick_a), 32'(mtick(0, A_P)));
                check("cmp_filt_b", 32'(filt_b), 32'(mf[1][3:0]));
                check("cmp_tick_b", 32'(tick_b), 32'(mtick(1, B_P)));
`ifdef GPIO_INPUT_FILTER_EDGE_EN
                check("cmp_rise_a", 32'(rise_a), 32'(mr[0]));
                check("cmp_fall_a", 32'(fall_a), 32'(mfl[0]));
                check("cmp_rise_b", 32'(rise_b), 32'(mr[1][3:0]));
                check("cmp_fall_b", 32'(fall_b), 32'(mfl[1][3:0]));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int   qual, cnt_ticks, changes, rises, falls;
        bit   flipped, seen_high;
        logic prev5;

        // Reset release with all pins held high
        #1;
        rst = 1'b1;
        raw_a = 8'hFF;
        started = 1'b1;
        repeat (3) step();
        check("rst_filt_a", 32'(filt_a), 32'h0);
        check("rst_tick_a", 32'(tick_a), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) check("rel_edge5", 32'(filt_a), 32'h00);
            if (i == 6) check("rel_edge6", 32'(filt_a), 32'hFF);
        end

        // Glitch rejection: 3-cycle pulse filtered, 4-cycle pulse passes
        raw_a = 8'h00;
        repeat (12) step();
        check("settle_low", 32'(filt_a), 32'h00);
        raw_a = 8'h01;
        repeat (3) step();
        raw_a = 8'h00;
        seen_high = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_high |= filt_a[0];
`ifdef GPIO_INPUT_FILTER_EDGE_EN
            seen_high |= rise_a[0];
`endif
        end
        check("glitch3", 32'(seen_high), 32'h0);
        raw_a = 8'h01;
        repeat (4) step();
        raw_a = 8'h00;
        step();
        check("pulse4_early", 32'(filt_a[0]), 32'h0);
        step();
        check("pulse4_rise", 32'(filt_a[0]), 32'h1);
`ifdef GPIO_INPUT_FILTER_EDGE_EN
        check("pulse4_rise_pulse", 32'(rise_a[0]), 32'h1);
`endif
        repeat (12) step();
        check("pulse4_back_low", 32'(filt_a), 32'h00);

        // Prescaler: tick every 5th cycle, flip on the 3rd qualifying tick
        cnt_ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick_b) cnt_ticks++;
        end
        check("tick_count", 32'(cnt_ticks), 32'd4);
        raw_b = 4'b0100;
        qual = 0;
        flipped = 1'b0;
        for (int j = 1; j <= 40 && !flipped; j++) begin
            if (tick_b && j >= 3) qual++;
            step();
            if (filt_b[2]) begin
                flipped = 1'b1;
                check("presc_flip_tick", 32'(qual), 32'd3);
                check("presc_other_bits", 32'(filt_b), 32'h4);
            end
        end
        check("presc_flip_seen", 32'(flipped), 32'h1);

        // Independence: pin1 rises at cycle 10, pin3 falls at cycle 12
        raw_a = 8'h08;
        repeat (12) step();
        check("indep_preset", 32'(filt_a), 32'h08);
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) raw_a[1] = 1'b1;
            if (c == 12) raw_a[3] = 1'b0;
            step();
            if (c == 14) check("indep_c14", 32'(filt_a), 32'h08);
            if (c == 15) check("indep_c15", 32'(filt_a), 32'h0A);
            if (c == 16) check("indep_c16", 32'(filt_a), 32'h0A);
            if (c == 17) check("indep_c17", 32'(filt_a), 32'h02);
        end

        // Async reset while pin0 is mid-count (cnt=2)
        raw_a = 8'h03;
        repeat (4) step();
        #1 rst = 1'b1;
        #1;
        check("async_clear", 32'(filt_a), 32'h00);
        check("async_tick", 32'(tick_a), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) check("requal_edge5", 32'(filt_a), 32'h00);
            if (i == 6) check("requal_edge6", 32'(filt_a), 32'h03);
        end

        // Pin5 toggles 1->0->1 with stable holds
        raw_a = 8'h20;
        repeat (12) step();
        check("pin5_preset", 32'(filt_a), 32'h20);
        changes = 0;
        rises = 0;
        falls = 0;
        prev5 = filt_a[5];
        for (int i = 0; i < 24; i++) begin
            if (i == 0)  raw_a = 8'h00;
            if (i == 12) raw_a = 8'h20;
            step();
            if (filt_a[5] != prev5) changes++;
`ifdef GPIO_INPUT_FILTER_EDGE_EN
            if (fall_a[5]) begin
                falls++;
                check("fall_coincide", 32'({prev5, filt_a[5]}), 32'b10);
            end
            if (rise_a[5]) begin
                rises++;
                check("rise_coincide", 32'({prev5, filt_a[5]}), 32'b01);
            end
`endif
            prev5 = filt_a[5];
        end
        check("pin5_changes", 32'(changes), 32'd2);
`ifdef GPIO_INPUT_FILTER_EDGE_EN
        check("pin5_falls", 32'(falls), 32'd1);
        check("pin5_rises", 32'(rises), 32'd1);
`endif

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
